cpu_control_seq: RTL and testbench

//  Multi-cycle control sequencer for the 16-bit WISC core: FSM steps each instruction FETCH->DECODE->EXEC->[MEM]->[WB].

---
 rtl/cpu_ctrl_pkg.sv | 52 +++++
 rtl/cpu_ctrl_decode.sv | 55 +++++
 rtl/cpu_control_seq.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_control_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the WISC control sequencer.
//   - opcode values for the 16 instructions
//   - sequencer state encoding
//   - pc_src select codes
//   - control word produced by the opcode decoder and held by the FSM
package cpu_ctrl_pkg;

    // ALU group occupies opcodes 0-7; opcode[2:0] is the ALU function.
    localparam logic [3:0] OpAdd    = 4'h0;
    localparam logic [3:0] OpSub    = 4'h1;
    localparam logic [3:0] OpXor    = 4'h2;
    localparam logic [3:0] OpRed    = 4'h3;
    localparam logic [3:0] OpSll    = 4'h4;
    localparam logic [3:0] OpSra    = 4'h5;
    localparam logic [3:0] OpRor    = 4'h6;
    localparam logic [3:0] OpPaddsb = 4'h7;
    localparam logic [3:0] OpLw     = 4'h8;
    localparam logic [3:0] OpSw     = 4'h9;
    localparam logic [3:0] OpLlb    = 4'hA;
    localparam logic [3:0] OpLhb    = 4'hB;
    localparam logic [3:0] OpB      = 4'hC;
    localparam logic [3:0] OpBr     = 4'hD;
    localparam logic [3:0] OpPcs    = 4'hE;
    localparam logic [3:0] OpHlt    = 4'hF;

    localparam logic [1:0] PcSrcSeq = 2'd0;  // PC+2
    localparam logic [1:0] PcSrcImm = 2'd1;  // PC+2+imm
    localparam logic [1:0] PcSrcReg = 2'd2;  // rs

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       load_type;
        logic       load_hi;
        logic       is_branch;
        logic       br_reg;     // branch target from rs instead of PC-relative immediate
    } ctrl_word_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: purely combinational opcode -> control word decoder.
// Ports:
//   opcode_i  in   4  registered instruction opcode
//   cw_o      out     control word (see cpu_ctrl_pkg::ctrl_word_t)
//   halt_o    out  1  opcode is HLT
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    output ctrl_word_t cw_o,
    output logic       halt_o
);

    always_comb begin
        cw_o   = '0;
        halt_o = 1'b0;
        unique case (opcode_i)
            OpLw: begin
                cw_o.alu_src    = 1'b1;
                cw_o.mem_read   = 1'b1;
                cw_o.mem_to_reg = 1'b1;
            end
            OpSw: begin
                cw_o.alu_src   = 1'b1;
                cw_o.mem_write = 1'b1;
            end
            OpLlb: begin
                cw_o.alu_src   = 1'b1;
                cw_o.load_type = 1'b1;
            end
            OpLhb: begin
                cw_o.alu_src   = 1'b1;
                cw_o.load_type = 1'b1;
                cw_o.load_hi   = 1'b1;
            end
            OpB: begin
                cw_o.is_branch = 1'b1;
            end
            OpBr: begin
                cw_o.is_branch = 1'b1;
                cw_o.br_reg    = 1'b1;
            end
            OpPcs: ;  // writes PC+2 through the WB path, register operand
            OpHlt: begin
                halt_o = 1'b1;
            end
            default: begin
                // Opcodes 0-7: ALU group writes rd.
                cw_o.alu_op  = opcode_i[2:0];
                cw_o.reg_dst = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_seq.sv
// cpu_control_seq: multi-cycle control sequencer for the 16-bit WISC core.
// Steps each instruction FETCH -> DECODE -> EXEC -> [MEM] -> [WB], handshakes with
// instruction/data memory, counts retired instructions and owns halt/timeout status.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   opcode, cond_true        instruction opcode (valid with imem_ack), branch condition
//   imem_ack, dmem_ack       memory completion handshakes
//   imem_req, dmem_req       memory requests
//   ir_load, pc_write/pc_src instruction register and PC strobes
//   reg_write .. load_hi     datapath control
//   halted, err, retired     sticky status and saturating retired count
module cpu_control_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ALU_W    = 3,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             cond_true,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_load,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic [ALU_W-1:0] alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             load_type,
    output logic             load_hi,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    ctrl_word_t       cw_q, cw_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;

    ctrl_word_t dec_cw;
    logic       dec_halt;
    logic       wait_busy;
    logic       wait_ack;
    logic       timeout;

    cpu_ctrl_decode u_decode (
        .opcode_i (opcode_q),
        .cw_o     (dec_cw),
        .halt_o   (dec_halt)
    );

    // Outputs decoded from registered state and control word only, so an async
    // reset drops every strobe immediately.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PcSrcSeq;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        load_type  = 1'b0;
        load_hi    = 1'b0;
        unique case (state_q)
            StFetch: begin
                // Reset leaves the state in FETCH; keep the request low while held.
                imem_req = ~rst;
                ir_load  = ~rst & imem_ack;
            end
            StExec: begin
                alu_op  = ALU_W'(cw_q.alu_op);
                alu_src = cw_q.alu_src;
                reg_dst = cw_q.reg_dst;
                if (cw_q.is_branch) begin
                    pc_write = 1'b1;
                    if (cond_true) begin
                        pc_src = cw_q.br_reg ? PcSrcReg : PcSrcImm;
                    end
                end
            end
            StMem: begin
                alu_op    = ALU_W'(cw_q.alu_op);
                alu_src   = cw_q.alu_src;
                reg_dst   = cw_q.reg_dst;
                dmem_req  = 1'b1;
                mem_read  = cw_q.mem_read;
                mem_write = cw_q.mem_write;
                pc_write  = cw_q.mem_write & dmem_ack;  // SW retires in its ack cycle
            end
            StWb: begin
                alu_op     = ALU_W'(cw_q.alu_op);
                alu_src    = cw_q.alu_src;
                reg_dst    = cw_q.reg_dst;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = cw_q.mem_to_reg;
                load_type  = cw_q.load_type;
                load_hi    = cw_q.load_hi;
            end
            default: ;
        endcase
    end

    assign halted  = halted_q;
    assign err     = err_q;
    assign retired = retired_q;

    // Acks only count while the matching request is raised.
    assign wait_busy = imem_req | dmem_req;
    assign wait_ack  = (imem_req & imem_ack) | (dmem_req & dmem_ack);
    assign timeout   = wait_busy & ~wait_ack & (wait_cnt_q == WaitLast);

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        cw_d       = cw_q;
        halted_d   = halted_q;
        err_d      = err_q;
        wait_cnt_d = '0;
        retired_d  = retired_q;

        unique case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    opcode_d = opcode;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                cw_d = dec_cw;
                if (dec_halt) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cw_q.mem_read || cw_q.mem_write) begin
                    state_d = StMem;
                end else if (cw_q.is_branch) begin
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ack) begin
                    state_d = cw_q.mem_read ? StWb : StFetch;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase

        if (wait_busy && !wait_ack) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end

        if (timeout) begin
            state_d    = StHalt;
            halted_d   = 1'b1;
            err_d      = 1'b1;
            wait_cnt_d = '0;
        end

        // Saturate rather than wrap.
        if (pc_write && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            opcode_q   <= '0;
            cw_q       <= '0;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            cw_q       <= cw_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_cpu_control_seq.sv
// tb_cpu_control_seq: directed bench for cpu_control_seq. Two instances share the
// stimulus: u_dut with default parameters and u_dut_s with a 2-bit retired counter.
module tb_cpu_control_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       cond_true, imem_ack, dmem_ack;

    logic       imem_req, dmem_req, ir_load, pc_write, reg_write, reg_dst, alu_src;
    logic       mem_read, mem_write, mem_to_reg, load_type, load_hi, halted, err;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [15:0] retired;

    logic       imem_req_s, dmem_req_s, ir_load_s, pc_write_s, reg_write_s, reg_dst_s;
    logic       alu_src_s, mem_read_s, mem_write_s, mem_to_reg_s, load_type_s, load_hi_s;
    logic       halted_s, err_s;
    logic [1:0] pc_src_s;
    logic [2:0] alu_op_s;
    logic [1:0] retired_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_control_seq u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .cond_true(cond_true),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .load_type(load_type),
        .load_hi(load_hi), .halted(halted), .err(err), .retired(retired)
    );

    cpu_control_seq #(.CNT_W(2)) u_dut_s (
        .clk(clk), .rst(rst), .opcode(opcode), .cond_true(cond_true),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req_s),
        .dmem_req(dmem_req_s), .ir_load(ir_load_s), .pc_write(pc_write_s),
        .pc_src(pc_src_s), .reg_write(reg_write_s), .reg_dst(reg_dst_s),
        .alu_src(alu_src_s), .alu_op(alu_op_s), .mem_read(mem_read_s),
        .mem_write(mem_write_s), .mem_to_reg(mem_to_reg_s), .load_type(load_type_s),
        .load_hi(load_hi_s), .halted(halted_s), .err(err_s), .retired(retired_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Present an opcode with a zero-wait ack; returns at the start of DECODE.
    task automatic fetch_op(input logic [3:0] op);
        opcode   = op;
        imem_ack = 1'b1;
        mid();
        chk("fetch_ir_load", ir_load, 1);
        next_cyc();
        imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        imem_ack  = 1'b0;
        dmem_ack  = 1'b0;
        cond_true = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; opcode = 4'h0; cond_true = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        mid();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_ir_load", ir_load, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_retired", retired, 0);
        next_cyc();
        rst = 1'b0;

        // ADD, zero wait
        opcode = 4'h0; imem_ack = 1'b1;
        mid();
        chk("add_c1_imem_req", imem_req, 1);
        chk("add_c1_ir_load", ir_load, 1);
        next_cyc(); imem_ack = 1'b0;
        mid();
        chk("add_c2_ir_load", ir_load, 0);
        chk("add_c2_imem_req", imem_req, 0);
        next_cyc();
        mid();
        chk("add_c3_reg_dst", reg_dst, 1);
        chk("add_c3_alu_op", alu_op, 0);
        chk("add_c3_reg_write", reg_write, 0);
        chk("add_c3_pc_write", pc_write, 0);
        next_cyc();
        mid();
        chk("add_c4_reg_write", reg_write, 1);
        chk("add_c4_reg_dst", reg_dst, 1);
        chk("add_c4_pc_write", pc_write, 1);
        chk("add_c4_pc_src", pc_src, 0);
        chk("add_c4_mem_to_reg", mem_to_reg, 0);
        next_cyc();
        mid();
        chk("add_retired", retired, 1);
        chk("add_back_fetch", imem_req, 1);

        // LW with dmem_ack on the 4th MEM cycle
        do_reset();
        fetch_op(4'h8);
        next_cyc();
        mid();
        chk("lw_exec_alu_src", alu_src, 1);
        chk("lw_exec_reg_dst", reg_dst, 0);
        chk("lw_exec_dmem_req", dmem_req, 0);
        next_cyc();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            mid();
            chk("lw_mem_dmem_req", dmem_req, 1);
            chk("lw_mem_read", mem_read, 1);
            chk("lw_mem_pc_write", pc_write, 0);
            next_cyc();
        end
        dmem_ack = 1'b0;
        mid();
        chk("lw_wb_mem_to_reg", mem_to_reg, 1);
        chk("lw_wb_reg_write", reg_write, 1);
        chk("lw_wb_pc_write", pc_write, 1);
        chk("lw_wb_mem_read", mem_read, 0);
        next_cyc();
        mid();
        chk("lw_retired", retired, 1);
        next_cyc();

        // B taken, B not taken, BR taken
        fetch_op(4'hC);
        next_cyc(); cond_true = 1'b1;
        mid();
        chk("b_t_pc_write", pc_write, 1);
        chk("b_t_pc_src", pc_src, 1);
        chk("b_t_reg_write", reg_write, 0);
        next_cyc(); cond_true = 1'b0;
        fetch_op(4'hC);
        next_cyc();
        mid();
        chk("b_nt_pc_write", pc_write, 1);
        chk("b_nt_pc_src", pc_src, 0);
        chk("b_nt_reg_write", reg_write, 0);
        next_cyc();
        fetch_op(4'hD);
        next_cyc(); cond_true = 1'b1;
        mid();
        chk("br_t_pc_src", pc_src, 2);
        next_cyc(); cond_true = 1'b0;
        mid();
        chk("br_retired", retired, 4);
        next_cyc();

        // LHB
        fetch_op(4'hB);
        next_cyc();
        mid();
        chk("lhb_exec_alu_src", alu_src, 1);
        chk("lhb_exec_reg_dst", reg_dst, 0);
        next_cyc();
        mid();
        chk("lhb_wb_load_type", load_type, 1);
        chk("lhb_wb_load_hi", load_hi, 1);
        chk("lhb_wb_reg_write", reg_write, 1);
        next_cyc();

        // SW with immediate ack
        fetch_op(4'h9);
        next_cyc();
        next_cyc();
        dmem_ack = 1'b1;
        mid();
        chk("sw_mem_write", mem_write, 1);
        chk("sw_pc_write", pc_write, 1);
        chk("sw_pc_src", pc_src, 0);
        chk("sw_reg_write", reg_write, 0);
        next_cyc(); dmem_ack = 1'b0;
        mid();
        chk("sw_retired", retired, 6);
        next_cyc();

        // SW aborted by reset in MEM
        fetch_op(4'h9);
        next_cyc();
        next_cyc();
        mid();
        chk("swab_mem_write", mem_write, 1);
        chk("swab_dmem_req", dmem_req, 1);
        #1 rst = 1'b1;
        #1;
        chk("swab_rst_mem_write", mem_write, 0);
        chk("swab_rst_dmem_req", dmem_req, 0);
        chk("swab_rst_retired", retired, 0);
        next_cyc();
        rst = 1'b0;

        // HLT, acks toggling while halted
        fetch_op(4'hF);
        mid();
        chk("hlt_decode_halted", halted, 0);
        next_cyc();
        mid();
        chk("hlt_halted", halted, 1);
        chk("hlt_err", err, 0);
        next_cyc();
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            dmem_ack = ~i[0];
            mid();
            chk("hlt_imem_req", imem_req, 0);
            chk("hlt_dmem_req", dmem_req, 0);
            chk("hlt_pc_write", pc_write, 0);
            chk("hlt_still", halted, 1);
            next_cyc();
        end
        chk("hlt_retired", retired, 0);

        // Fetch timeout
        do_reset();
        for (int i = 0; i < 15; i++) begin
            mid();
            chk("to_imem_req", imem_req, 1);
            chk("to_err_low", err, 0);
            next_cyc();
        end
        mid();
        chk("to_req_dropped", imem_req, 0);
        chk("to_err", err, 1);
        chk("to_halted", halted, 1);
        #1 rst = 1'b1;
        #1;
        chk("to_rst_err", err, 0);
        chk("to_rst_halted", halted, 0);
        next_cyc();
        rst = 1'b0;
        mid();
        chk("to_rst_fetch", imem_req, 1);
        next_cyc();

        // Five ALU ops: retired saturation on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch_op(i[3:0]);
            next_cyc();
            mid();
            chk("alu_seq_alu_op", alu_op, i);
            chk("alu_seq_reg_dst", reg_dst, 1);
            next_cyc();
            next_cyc();
        end
        mid();
        chk("sat_retired_wide", retired, 5);
        chk("sat_retired_narrow", retired_s, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
